muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: iterative radix-2 datapath with a fixed 32-cycle latency.
// Operates on magnitudes; signs and RISC-V special cases are applied when the result is written.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic        reg_write
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t      r_state;
    logic [4:0]  r_count;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_divisor;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_negQ;
    logic        r_negR;
    logic        r_bZero;
    logic [4:0]  r_rd;
    logic        r_busy;
    logic        r_done;
    logic        r_regWrite;
    logic [31:0] r_result;
    logic [4:0]  r_rdOut;

    logic        w_aSigned;
    logic        w_bSigned;
    logic        w_aNeg;
    logic        w_bNeg;
    logic [31:0] w_aMag;
    logic [31:0] w_bMag;
    logic [31:0] w_addend;
    logic [32:0] w_sum;
    logic [32:0] w_shift;
    logic        w_fits;
    logic [31:0] w_diffLow;
    logic [31:0] w_nextHi;
    logic [31:0] w_nextLo;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_final;

    assign w_aSigned = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_bSigned = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_aNeg    = w_aSigned && operand_a[31];
    assign w_bNeg    = w_bSigned && operand_b[31];
    assign w_aMag    = w_aNeg ? (~operand_a + 32'd1) : operand_a;
    assign w_bMag    = w_bNeg ? (~operand_b + 32'd1) : operand_b;

    // Multiply: r_hi accumulates, r_lo holds the multiplier and collects low product bits.
    assign w_addend  = r_lo[0] ? r_divisor : 32'd0;
    assign w_sum     = {1'b0, r_hi} + {1'b0, w_addend};

    // Divide: r_hi is the partial remainder, r_lo shifts the dividend out and the quotient in.
    assign w_shift   = {r_hi, r_lo[31]};
    assign w_fits    = w_shift >= {1'b0, r_divisor};
    assign w_diffLow = w_shift[31:0] - r_divisor;

    always_comb begin
        w_nextHi = w_sum[32:1];
        w_nextLo = {w_sum[0], r_lo[31:1]};
        if (r_op[2]) begin
            w_nextHi = w_fits ? w_diffLow : w_shift[31:0];
            w_nextLo = {r_lo[30:0], w_fits};
        end
    end

    // Signed overflow falls out of the magnitude path; only divide-by-zero needs an override.
    assign w_prod = r_negQ ? (~{w_nextHi, w_nextLo} + 64'd1) : {w_nextHi, w_nextLo};
    assign w_quo  = r_bZero ? 32'hFFFF_FFFF : (r_negQ ? (~w_nextLo + 32'd1) : w_nextLo);
    assign w_rem  = r_bZero ? r_a : (r_negR ? (~w_nextHi + 32'd1) : w_nextHi);

    always_comb begin
        w_final = w_prod[63:32];
        case (r_op)
            3'b000:          w_final = w_prod[31:0];
            3'b100, 3'b101:  w_final = w_quo;
            3'b110, 3'b111:  w_final = w_rem;
            default:         w_final = w_prod[63:32];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= 5'd0;
            r_op       <= 3'd0;
            r_a        <= 32'd0;
            r_divisor  <= 32'd0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_negQ     <= 1'b0;
            r_negR     <= 1'b0;
            r_bZero    <= 1'b0;
            r_rd       <= 5'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_regWrite <= 1'b0;
            r_result   <= 32'd0;
            r_rdOut    <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op      <= funct3;
                        r_a       <= operand_a;
                        r_divisor <= w_bMag;
                        r_hi      <= 32'd0;
                        r_lo      <= w_aMag;
                        r_negQ    <= w_aNeg ^ w_bNeg;
                        r_negR    <= w_aNeg;
                        r_bZero   <= (operand_b == 32'd0);
                        r_rd      <= rd_in;
                        r_count   <= 5'd0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_hi    <= w_nextHi;
                    r_lo    <= w_nextLo;
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_regWrite <= (r_rd != 5'd0);
                        r_result   <= w_final;
                        r_rdOut    <= r_rd;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_done     <= 1'b0;
                    r_regWrite <= 1'b0;
                    r_busy     <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign rd_out    = r_rdOut;
    assign reg_write = r_regWrite;

endmodule
